// File: rtl/indicator_pkg.sv
// Shared encodings for the indicator bank: LED channel modes and the
// seven-segment glyph table (active-high, gfedcba).
package indicator_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ACT   = 2'b01,
    MODE_ON    = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  // Indexed by nibble value; outputs are inverted at the pins.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h7f;

endpackage

// File: rtl/act_stretch.sv
// One activity channel: latches evt until the next clk_en tick, then
// (re)loads a hold counter that keeps act high for max(stretch,1) ticks.
module act_stretch #(
  parameter int STRETCH_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 evt,
  input  logic [STRETCH_W-1:0] stretch,
  output logic                 act
);

  logic                 pend_q, pend_d;
  logic [STRETCH_W-1:0] cnt_q, cnt_d;
  logic [STRETCH_W-1:0] load_val;

  always_comb begin
    load_val = (stretch == '0) ? STRETCH_W'(1) : stretch;
    pend_d   = pend_q | evt;
    cnt_d    = cnt_q;
    if (clk_en) begin
      // evt coincident with the tick counts for this tick, not the next
      pend_d = 1'b0;
      if (pend_q | evt) begin
        cnt_d = load_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign act = (cnt_q != '0);

endmodule

// File: rtl/indicator_bank.sv
// LED channel drivers (off/activity/solid/blink) plus a registered hex display.
// Define INDICATOR_BANK_BLINK_EN to build the blink divider; otherwise blink == solid.
module indicator_bank
  import indicator_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int STRETCH_W = 16,
  parameter int BLINK_W   = 22,
  parameter int NDIG      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [NCH-1:0]       evt,
  input  logic [2*NCH-1:0]     mode,
  input  logic [STRETCH_W-1:0] stretch,
  input  logic [4*NDIG-1:0]    value,
  input  logic                 blank_lz,
  output logic [NCH-1:0]       led,
  output logic [7*NDIG-1:0]    hex
);

  logic [NCH-1:0]    act;
  logic              blink_phase;
  logic [NCH-1:0]    led_q, led_d;
  logic [7*NDIG-1:0] hex_q, hex_d;
  logic              lead;
  logic [3:0]        nib;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    act_stretch #(.STRETCH_W(STRETCH_W)) u_act (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .evt     (evt[g]),
      .stretch (stretch),
      .act     (act[g])
    );
  end

`ifdef INDICATOR_BANK_BLINK_EN
  logic [BLINK_W-1:0] blink_q, blink_d;

  always_comb begin
    blink_d = clk_en ? blink_q + 1'b1 : blink_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_d;
  end

  assign blink_phase = blink_q[BLINK_W-1];
`else
  // No divider: blink mode degenerates to solid on.
  assign blink_phase = 1'b1 | (BLINK_W == 0);
`endif

  always_comb begin
    led_d = led_q;
    if (clk_en) begin
      for (int i = 0; i < NCH; i++) begin
        case (mode[2*i +: 2])
          MODE_OFF:   led_d[i] = 1'b0;
          MODE_ACT:   led_d[i] = act[i];
          MODE_ON:    led_d[i] = 1'b1;
          MODE_BLINK: led_d[i] = blink_phase;
        endcase
      end
    end
  end

  // Scan from the top digit; lead stays set until a nonzero nibble is seen.
  always_comb begin
    hex_d = hex_q;
    lead  = 1'b1;
    nib   = 4'h0;
    if (clk_en) begin
      for (int d = NDIG - 1; d >= 0; d--) begin
        nib = value[4*d +: 4];
        if (nib != 4'h0) lead = 1'b0;
        if (blank_lz && lead && (d != 0)) hex_d[7*d +: 7] = SEG_BLANK;
        else                              hex_d[7*d +: 7] = ~SEG_TAB[nib];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
      hex_q <= {NDIG{SEG_BLANK}};
    end else begin
      led_q <= led_d;
      hex_q <= hex_d;
    end
  end

  assign led = led_q;
  assign hex = hex_q;

endmodule

// File: tb/tb_indicator_bank.sv
// Self-checking bench for indicator_bank: hex table vectors, hand-written
// hold/retrigger/reset/blink sequences, and random traffic against a tick-level model.
module tb_indicator_bank;

  localparam int NCH  = 4;
  localparam int SW   = 8;
  localparam int BW   = 3;
  localparam int NDIG = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic [NCH-1:0]    evt;
  logic [2*NCH-1:0]  mode;
  logic [SW-1:0]     stretch;
  logic [4*NDIG-1:0] value;
  logic              blank_lz;
  logic [NCH-1:0]    led;
  logic [7*NDIG-1:0] hex;

  always #5 clk = ~clk;

  indicator_bank #(.NCH(NCH), .STRETCH_W(SW), .BLINK_W(BW), .NDIG(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .evt      (evt),
    .mode     (mode),
    .stretch  (stretch),
    .value    (value),
    .blank_lz (blank_lz),
    .led      (led),
    .hex      (hex)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Independent glyph table (active-high gfedcba)
  localparam logic [6:0] REF_SEG [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
  };

  // Model: a channel is lit at tick t if its most recent load L satisfies L < t <= L+len.
  int                tick_n;
  bit                pend      [NCH];
  int                last_load [NCH];
  int                last_len  [NCH];
  logic [NCH-1:0]    m_led;
  logic [7*NDIG-1:0] m_hex;

  typedef struct {
    logic [15:0] value;
    logic        blank;
    logic [6:0]  d3, d2, d1, d0;
  } hex_vec_t;

  hex_vec_t tv [8];

  function automatic logic [7*NDIG-1:0] ref_hex(input logic [4*NDIG-1:0] v, input logic b);
    int top = 0;
    logic [7*NDIG-1:0] r;
    for (int d = 0; d < NDIG; d++) if (v[4*d +: 4] != 4'h0) top = d;
    for (int d = 0; d < NDIG; d++)
      r[7*d +: 7] = (b && d > top) ? 7'h7f : ~REF_SEG[v[4*d +: 4]];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    tick_n = 0;
    for (int i = 0; i < NCH; i++) begin
      pend[i] = 1'b0;
      last_load[i] = -1;
      last_len[i] = 0;
    end
    m_led = '0;
    m_hex = {NDIG{7'h7f}};
  endtask

  // One clk cycle: advance the model with the inputs present at the edge, then compare.
  task automatic cycle();
    bit blink, lit;
    @(posedge clk);
    for (int i = 0; i < NCH; i++) if (evt[i]) pend[i] = 1'b1;
    if (clk_en) begin
`ifdef INDICATOR_BANK_BLINK_EN
      blink = ((tick_n % (1 << BW)) >= (1 << (BW - 1)));
`else
      blink = 1'b1;
`endif
      for (int i = 0; i < NCH; i++) begin
        lit = (last_load[i] >= 0) && (tick_n > last_load[i]) &&
              (tick_n <= last_load[i] + last_len[i]);
        case (mode[2*i +: 2])
          2'b00:   m_led[i] = 1'b0;
          2'b01:   m_led[i] = lit;
          2'b10:   m_led[i] = 1'b1;
          default: m_led[i] = blink;
        endcase
        if (pend[i]) begin
          last_load[i] = tick_n;
          last_len[i]  = (stretch == 0) ? 1 : int'(stretch);
          pend[i]      = 1'b0;
        end
      end
      m_hex = ref_hex(value, blank_lz);
      tick_n++;
    end
    #1;
    check("led_model", 64'(led), 64'(m_led));
    check("hex_model", 64'(hex), 64'(m_hex));
  endtask

  // clk_en every 4th clk, optional 1-clk evt pulse between ticks
  task automatic do_tick(input logic [NCH-1:0] pulse);
    clk_en = 1'b0; evt = '0;
    cycle();
    evt = pulse;
    cycle();
    evt = '0;
    cycle();
    clk_en = 1'b1;
    cycle();
    clk_en = 1'b0;
  endtask

  task automatic do_reset(input logic [NCH-1:0] evt_during);
    rst = 1'b1;
    evt = evt_during;
    #2;
    model_reset();
    check("rst_led", 64'(led), 64'd0);
    check("rst_hex", 64'(hex), 64'({NDIG{7'h7f}}));
    @(posedge clk);
    @(posedge clk);
    #1;
    evt = '0;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; clk_en = 1'b0; evt = '0; mode = '0; stretch = '0;
    value = '0; blank_lz = 1'b0;
    model_reset();
    #1;
    do_reset('0);

    // Hex decode table (inverted glyphs written out as constants)
    tv[0] = '{16'h00A3, 1'b1, 7'h7f, 7'h7f, 7'h08, 7'h30};
    tv[1] = '{16'h0000, 1'b1, 7'h7f, 7'h7f, 7'h7f, 7'h40};
    tv[2] = '{16'h0000, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40};
    tv[3] = '{16'h00A3, 1'b0, 7'h40, 7'h40, 7'h08, 7'h30};
    tv[4] = '{16'h0F00, 1'b1, 7'h7f, 7'h0e, 7'h40, 7'h40};
    tv[5] = '{16'h8001, 1'b1, 7'h00, 7'h40, 7'h40, 7'h79};
    tv[6] = '{16'h0010, 1'b1, 7'h7f, 7'h7f, 7'h79, 7'h40};
    tv[7] = '{16'hBCDE, 1'b1, 7'h03, 7'h46, 7'h21, 7'h06};
    for (int k = 0; k < 8; k++) begin
      value = tv[k].value;
      blank_lz = tv[k].blank;
      do_tick('0);
      check("hex_table", 64'(hex), 64'({tv[k].d3, tv[k].d2, tv[k].d1, tv[k].d0}));
    end

    // Basic hold: stretch 3, lit on ticks 2..4 after the pulse
    do_reset('0);
    mode = 8'b01010101; stretch = 8'd3;
    for (int k = 1; k <= 7; k++) begin
      do_tick(k == 1 ? 4'b0001 : 4'b0000);
      check("hold3", 64'(led[0]), 64'(k >= 2 && k <= 4));
    end

    // Retrigger at count 2: lit continuously ticks 2..10
    do_reset('0);
    stretch = 8'd5;
    for (int k = 1; k <= 11; k++) begin
      do_tick((k == 1 || k == 5) ? 4'b0001 : 4'b0000);
      check("retrigger", 64'(led[0]), 64'(k >= 2 && k <= 10));
    end

    // stretch 0 behaves as 1
    do_reset('0);
    stretch = 8'd0;
    for (int k = 1; k <= 4; k++) begin
      do_tick(k == 1 ? 4'b0010 : 4'b0000);
      check("stretch0", 64'(led[1]), 64'(k == 2));
    end

    // Blink with a 3-bit divider
    do_reset('0);
    mode = 8'hFF;
    for (int k = 1; k <= 16; k++) begin
      do_tick('0);
`ifdef INDICATOR_BANK_BLINK_EN
      check("blink", 64'(led[0]), 64'(((k - 1) / 4) % 2 == 1));
`else
      check("blink_as_on", 64'(led[0]), 64'd1);
`endif
    end

    // Reset mid-hold, evt present only during reset must be dropped
    do_reset('0);
    mode = 8'b01010101; stretch = 8'd8;
    for (int k = 1; k <= 5; k++) do_tick(k == 1 ? 4'b0001 : 4'b0000);
    check("pre_rst_hold", 64'(led[0]), 64'd1);
    do_reset(4'b1111);
    for (int k = 1; k <= 12; k++) begin
      do_tick('0);
      check("post_rst_dark", 64'(led), 64'd0);
    end

    // Random traffic against the model
    do_reset('0);
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        r = $urandom; mode = r[2*NCH-1:0];
        r = $urandom_range(0, 6); stretch = r[SW-1:0];
        blank_lz = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom;
        value = r[15:0] >> (4 * $urandom_range(0, 4));
      end
      clk_en = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NCH; i++) evt[i] = ($urandom_range(0, 9) == 0);
      cycle();
      if (c == 2500) do_reset(4'b0101);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
